// File: rtl/vga_timing_gen_if.sv
// Video timing bundle from the timing generator to pixel logic and the VGA pins.
interface vga_timing_gen_if;
  logic       ready;
  logic       vga_hs;
  logic       vga_vs;
  logic       active;
  logic       vblank;
  logic [9:0] x;
  logic [9:0] y;
  logic       frame_start;

  modport master (
    output ready, vga_hs, vga_vs, active, vblank, x, y, frame_start
  );

  modport slave (
    input ready, vga_hs, vga_vs, active, vblank, x, y, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA sync/position generator in the pixel clock domain, held idle until the PLL
// has stayed locked for RST_HOLD consecutive cycles.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned RST_HOLD = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pll_locked,
  vga_timing_gen_if.master  vid
);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Boundaries are 11 bits wide so a sync ending exactly at 1024 still compares correctly.
  localparam logic [10:0] HActEnd   = 11'(H_ACTIVE);
  localparam logic [10:0] HSyncBeg  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HSyncEnd  = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VActEnd   = 11'(V_ACTIVE);
  localparam logic [10:0] VSyncBeg  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VSyncEnd  = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0]  HLast     = 10'(HTotal - 1);
  localparam logic [9:0]  VLast     = 10'(VTotal - 1);
  localparam logic [7:0]  HoldLast  = 8'(RST_HOLD - 1);

  typedef enum logic [1:0] {
    StWaitLock,
    StHold,
    StRun
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;

  logic       ready_q;
  logic       hs_q, vs_q, active_q, vblank_q, frame_start_q;
  logic [9:0] x_q, y_q;

  // ---------------------------------------------------------------------------
  // State and counter registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StWaitLock;
      hold_q  <= '0;
      h_q     <= '0;
      v_q     <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      h_q     <= h_d;
      v_q     <= v_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    h_d     = h_q;
    v_d     = v_q;
    unique case (state_q)
      StWaitLock: begin
        hold_d = '0;
        h_d    = '0;
        v_d    = '0;
        if (pll_locked) begin
          state_d = StHold;
        end
      end
      StHold: begin
        if (!pll_locked) begin
          state_d = StWaitLock;
          hold_d  = '0;
        end else if (hold_q == HoldLast) begin
          state_d = StRun;
          hold_d  = '0;
          h_d     = '0;
          v_d     = '0;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      StRun: begin
        if (!pll_locked) begin
          state_d = StWaitLock;
          h_d     = '0;
          v_d     = '0;
        end else if (h_q == HLast) begin
          h_d = '0;
          v_d = (v_q == VLast) ? 10'd0 : v_q + 10'd1;
        end else begin
          h_d = h_q + 10'd1;
        end
      end
      default: begin
        state_d = StWaitLock;
        hold_d  = '0;
        h_d     = '0;
        v_d     = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Position decode, registered one cycle behind the counters
  // ---------------------------------------------------------------------------
  logic [10:0] h_ext, v_ext;
  logic        in_hsync, in_vsync, in_active, in_vblank, show;

  always_comb begin
    h_ext     = {1'b0, h_q};
    v_ext     = {1'b0, v_q};
    in_hsync  = (h_ext >= HSyncBeg) && (h_ext < HSyncEnd);
    in_vsync  = (v_ext >= VSyncBeg) && (v_ext < VSyncEnd);
    in_vblank = (v_ext >= VActEnd);
    in_active = (h_ext < HActEnd) && !in_vblank;
    // Only decode while RUN is both current and next, so entry and lock loss stay idle.
    show      = (state_q == StRun) && (state_d == StRun);
  end

  always_ff @(posedge clock) begin
    if (reset || !show) begin
      hs_q          <= ~HS_POL;
      vs_q          <= ~VS_POL;
      active_q      <= 1'b0;
      vblank_q      <= 1'b1;
      x_q           <= '0;
      y_q           <= '0;
      frame_start_q <= 1'b0;
    end else begin
      hs_q          <= in_hsync ? HS_POL : ~HS_POL;
      vs_q          <= in_vsync ? VS_POL : ~VS_POL;
      active_q      <= in_active;
      vblank_q      <= in_vblank;
      x_q           <= in_active ? h_q : 10'd0;
      y_q           <= in_vblank ? 10'd0 : v_q;
      frame_start_q <= (h_q == 10'd0) && (v_q == 10'd0);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= (state_d == StRun);
    end
  end

  assign vid.ready       = ready_q;
  assign vid.vga_hs      = hs_q;
  assign vid.vga_vs      = vs_q;
  assign vid.active      = active_q;
  assign vid.vblank      = vblank_q;
  assign vid.x           = x_q;
  assign vid.y           = y_q;
  assign vid.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: a lock-history model predicts every cycle's outputs.
module tb_vga_timing_gen;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned V_ACTIVE = 6;
  localparam int unsigned V_FP     = 2;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 3;
  localparam bit          HS_POL   = 1'b0;
  localparam bit          VS_POL   = 1'b1;
  localparam int unsigned RST_HOLD = 16;
  localparam int          HTot     = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int          VTot     = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int          FirstPix = RST_HOLD + 2;

  typedef struct packed {
    logic       ready;
    logic       hs;
    logic       vs;
    logic       active;
    logic       vblank;
    logic [9:0] x;
    logic [9:0] y;
    logic       fs;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  logic pll_locked;

  vga_timing_gen_if vif ();

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .HS_POL   (HS_POL),
    .VS_POL   (VS_POL),
    .RST_HOLD (RST_HOLD)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .pll_locked (pll_locked),
    .vid        (vif)
  );

  always #20 clock = ~clock;

  exp_t q[$];
  int   run = 0;  // consecutive edges with reset low and lock high
  int   checks = 0;
  int   errors = 0;
  int   cycle = 0;

  // Outputs follow purely from how long the PLL has been continuously locked.
  function automatic exp_t model(input int r);
    exp_t e;
    int   p, h, v;
    e.ready  = (r >= RST_HOLD + 1);
    e.hs     = !HS_POL;
    e.vs     = !VS_POL;
    e.active = 1'b0;
    e.vblank = 1'b1;
    e.x      = '0;
    e.y      = '0;
    e.fs     = 1'b0;
    if (r >= FirstPix) begin
      p = r - FirstPix;
      h = p % HTot;
      v = (p / HTot) % VTot;
      e.hs = (h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC) ? HS_POL : !HS_POL;
      e.vs = (v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC) ? VS_POL : !VS_POL;
      e.vblank = (v >= V_ACTIVE);
      e.active = (h < H_ACTIVE) && (v < V_ACTIVE);
      e.x      = e.active ? 10'(h) : 10'd0;
      e.y      = e.vblank ? 10'd0 : 10'(v);
      e.fs     = (h == 0) && (v == 0);
    end
    return e;
  endfunction

  function automatic void chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cycle, act, exp);
    end
  endfunction

  // Drive one edge's inputs and queue the response expected after that edge.
  task automatic cyc(input logic rst, input logic lk);
    reset      = rst;
    pll_locked = lk;
    if (rst || !lk) run = 0;
    else            run = run + 1;
    q.push_back(model(run));
    @(negedge clock);
  endtask

  task automatic hold_reset(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b1);
  endtask

  task automatic locked_for(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1);
  endtask

  // Monitor: compares every presented output cycle against the queued expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      cycle++;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("ready",       10'(vif.ready),       10'(e.ready));
        chk("vga_hs",      10'(vif.vga_hs),      10'(e.hs));
        chk("vga_vs",      10'(vif.vga_vs),      10'(e.vs));
        chk("active",      10'(vif.active),      10'(e.active));
        chk("vblank",      10'(vif.vblank),      10'(e.vblank));
        chk("x",           vif.x,                e.x);
        chk("y",           vif.y,                e.y);
        chk("frame_start", 10'(vif.frame_start), 10'(e.fs));
        if (errors > 200) begin
          $display("CHECKS %0d ERRORS %0d", checks, errors);
          $finish;
        end
      end
    end
  end

  initial begin : stimulus
    int len, kind;
    // Startup followed by one full frame plus part of the next.
    hold_reset(5);
    locked_for(FirstPix + HTot * VTot + 900);
    // Lock loss mid-line, then relock and restart at (0,0).
    hold_reset(2);
    locked_for(FirstPix + 3 * HTot + 300);
    cyc(1'b0, 1'b0);
    locked_for(FirstPix + 60);
    // Lock glitch while holding discards the partial hold count.
    hold_reset(5);
    locked_for(11);
    cyc(1'b0, 1'b0);
    locked_for(FirstPix + 20);
    // Reset in the middle of a frame, then a clean restart.
    locked_for(4 * HTot + 123);
    hold_reset(5);
    locked_for(FirstPix + 30);
    // Reset and lock loss on the same edge.
    cyc(1'b1, 1'b0);
    locked_for(FirstPix + 10);
    // Randomised segments of lock, glitches and resets.
    for (int s = 0; s < 30; s++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        hold_reset($urandom_range(1, 3));
      end else if (kind <= 2) begin
        len = $urandom_range(1, 3);
        for (int i = 0; i < len; i++) cyc(1'b0, 1'b0);
      end else begin
        locked_for($urandom_range(1, 1200));
      end
    end
    locked_for(FirstPix + 5);
    @(posedge clock);
    #2;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
